// File: rtl/pe_nbr_fifo_if.sv
// Handshake bundle between the upstream PE writer, the downstream PE reader and pe_nbr_fifo.
// When PE_NBR_FIFO_ERR_EN is defined the bundle also carries the sticky ovf_err/unf_err flags.
interface pe_nbr_fifo_if #(
   parameter int DW    = 16,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic          flush;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
`ifdef PE_NBR_FIFO_ERR_EN
   logic          ovf_err;
   logic          unf_err;
`endif

   modport master (
      output flush, wr_en, wr_data, rd_en,
`ifdef PE_NBR_FIFO_ERR_EN
      input  ovf_err, unf_err,
`endif
      input  rd_data, rd_valid, full, empty, count
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en,
`ifdef PE_NBR_FIFO_ERR_EN
      output ovf_err, unf_err,
`endif
      output rd_data, rd_valid, full, empty, count
   );
endinterface

// File: rtl/pe_nbr_fifo.sv
// Neighbour-data FIFO between two systolic PEs; 1-cycle registered read, zero output when idle.
// Optional sticky overflow/underflow flags are built when PE_NBR_FIFO_ERR_EN is defined.
module pe_nbr_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 16
) (
   input logic          clk,
   input logic          rst,
   pe_nbr_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [DW-1:0] mem [DEPTH];
   logic          ptr_empty;
   logic          ptr_full;
   logic          rd_acc;
   logic          wr_acc;

   // Status comes from the registered pointers only, never from this cycle's requests.
   assign ptr_empty = (wr_ptr == rd_ptr);
   assign ptr_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A write at full is still taken when a read frees the head slot in the same cycle.
   assign rd_acc = bus.rd_en && !ptr_empty;
   assign wr_acc = bus.wr_en && (!ptr_full || rd_acc);

   assign bus.empty = ptr_empty;
   assign bus.full  = ptr_full;
   assign bus.count = wr_ptr - rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else if (bus.flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         bus.rd_valid <= rd_acc;
         bus.rd_data  <= rd_acc ? mem[rd_ptr[AW-1:0]] : '0;
      end
   end

   // Storage has no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_acc && !bus.flush) begin
         mem[wr_ptr[AW-1:0]] <= bus.wr_data;
      end
   end

`ifdef PE_NBR_FIFO_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ovf_err <= 1'b0;
         bus.unf_err <= 1'b0;
      end else if (bus.flush) begin
         bus.ovf_err <= 1'b0;
         bus.unf_err <= 1'b0;
      end else begin
         if (bus.wr_en && !wr_acc) begin
            bus.ovf_err <= 1'b1;
         end
         if (bus.rd_en && ptr_empty) begin
            bus.unf_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pe_nbr_fifo.sv
// Self-checking bench for pe_nbr_fifo: queue reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_pe_nbr_fifo;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   cmp_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   pe_nbr_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

   pe_nbr_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue holding the FIFO contents in order.
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_data;
   logic          exp_valid;
   logic          exp_ovf;
   logic          exp_unf;

   always @(posedge clk or posedge rst) begin
      bit rd_ok;
      bit wr_ok;
      if (rst) begin
         q.delete();
         exp_data  = '0;
         exp_valid = 1'b0;
         exp_ovf   = 1'b0;
         exp_unf   = 1'b0;
      end else if (bus.flush) begin
         q.delete();
         exp_data  = '0;
         exp_valid = 1'b0;
         exp_ovf   = 1'b0;
         exp_unf   = 1'b0;
      end else begin
         rd_ok = bus.rd_en && (q.size() > 0);
         wr_ok = bus.wr_en && ((q.size() < DEPTH) || rd_ok);
         if (bus.wr_en && !wr_ok) exp_ovf = 1'b1;
         if (bus.rd_en && q.size() == 0) exp_unf = 1'b1;
         if (rd_ok) begin
            exp_data  = q.pop_front();
            exp_valid = 1'b1;
         end else begin
            exp_data  = '0;
            exp_valid = 1'b0;
         end
         if (wr_ok) q.push_back(bus.wr_data);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         check("cmp_rd_valid", {31'd0, bus.rd_valid}, {31'd0, exp_valid});
         check("cmp_rd_data", {16'd0, bus.rd_data}, {16'd0, exp_data});
         check("cmp_count", {27'd0, bus.count}, q.size());
         check("cmp_empty", {31'd0, bus.empty}, {31'd0, q.size() == 0});
         check("cmp_full", {31'd0, bus.full}, {31'd0, q.size() == DEPTH});
`ifdef PE_NBR_FIFO_ERR_EN
         check("cmp_ovf_err", {31'd0, bus.ovf_err}, {31'd0, exp_ovf});
         check("cmp_unf_err", {31'd0, bus.unf_err}, {31'd0, exp_unf});
`endif
      end
   end

   // One clock of stimulus; inputs change at the falling edge and return there.
   task automatic cyc(input bit we, input logic [DW-1:0] wd, input bit re, input bit fl);
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.rd_en   = re;
      bus.flush   = fl;
      @(posedge clk);
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.flush = 1'b0;
   endtask

   initial begin
      bus.flush   = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      cmp_en = 1'b1;
      check("reset_count", {27'd0, bus.count}, 32'd0);
      check("reset_empty", {31'd0, bus.empty}, 32'd1);
      check("reset_full", {31'd0, bus.full}, 32'd0);
      check("reset_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      check("reset_rd_data", {16'd0, bus.rd_data}, 32'd0);

      // Basic order
      cyc(1, 16'h3C00, 0, 0);
      cyc(1, 16'h4000, 0, 0);
      cyc(1, 16'h4200, 0, 0);
      check("basic_count3", {27'd0, bus.count}, 32'd3);
      cyc(0, '0, 1, 0);
      check("basic_rd0", {15'd0, bus.rd_valid, bus.rd_data}, 32'h1_3C00);
      cyc(0, '0, 1, 0);
      check("basic_rd1", {15'd0, bus.rd_valid, bus.rd_data}, 32'h1_4000);
      cyc(0, '0, 1, 0);
      check("basic_rd2", {15'd0, bus.rd_valid, bus.rd_data}, 32'h1_4200);
      check("basic_empty", {31'd0, bus.empty}, 32'd1);
      check("basic_count0", {27'd0, bus.count}, 32'd0);
      cyc(0, '0, 0, 0);
      check("idle_zero", {15'd0, bus.rd_valid, bus.rd_data}, 32'd0);

      // Fill to full, then a dropped write
      for (int i = 1; i <= DEPTH; i++) cyc(1, DW'(i), 0, 0);
      check("fill_full", {31'd0, bus.full}, 32'd1);
      check("fill_count", {27'd0, bus.count}, 32'd16);
      cyc(1, 16'hFFFF, 0, 0);
      check("drop_count", {27'd0, bus.count}, 32'd16);
`ifdef PE_NBR_FIFO_ERR_EN
      check("drop_ovf", {31'd0, bus.ovf_err}, 32'd1);
`endif

      // Simultaneous read and write at full
      cyc(1, 16'h5555, 1, 0);
      check("full_rw_data", {16'd0, bus.rd_data}, 32'h0001);
      check("full_rw_count", {27'd0, bus.count}, 32'd16);
      check("full_rw_full", {31'd0, bus.full}, 32'd1);
      for (int i = 2; i <= DEPTH; i++) begin
         cyc(0, '0, 1, 0);
         check("drain_data", {16'd0, bus.rd_data}, i);
      end
      cyc(0, '0, 1, 0);
      check("drain_last", {16'd0, bus.rd_data}, 32'h5555);
      check("drain_empty", {31'd0, bus.empty}, 32'd1);
      cyc(0, '0, 1, 0);
      check("empty_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
`ifdef PE_NBR_FIFO_ERR_EN
      check("empty_unf", {31'd0, bus.unf_err}, 32'd1);
`endif

      // Simultaneous read and write at empty: no fall-through
      cyc(1, 16'h1234, 1, 0);
      check("empty_rw", {15'd0, bus.rd_valid, bus.rd_data}, 32'd0);
      check("empty_rw_count", {27'd0, bus.count}, 32'd1);
      cyc(0, '0, 1, 0);
      check("empty_rw_follow", {15'd0, bus.rd_valid, bus.rd_data}, 32'h1_1234);

      // Wrap-around across two pointer wraps
      for (int i = 0; i < 40; i++) begin
         cyc(1, DW'(i), 0, 0);
         cyc(0, '0, 1, 0);
         check("wrap_data", {15'd0, bus.rd_valid, bus.rd_data}, 32'h1_0000 | i);
      end
      check("wrap_empty", {31'd0, bus.empty}, 32'd1);

      // Flush beats a concurrent write
      for (int i = 0; i < 5; i++) cyc(1, 16'hA000 + DW'(i), 0, 0);
      check("pre_flush_count", {27'd0, bus.count}, 32'd5);
      cyc(1, 16'hABCD, 0, 1);
      check("flush_count", {27'd0, bus.count}, 32'd0);
      check("flush_empty", {31'd0, bus.empty}, 32'd1);
`ifdef PE_NBR_FIFO_ERR_EN
      check("flush_errs", {30'd0, bus.ovf_err, bus.unf_err}, 32'd0);
`endif
      cyc(0, '0, 1, 0);
      check("flush_no_data", {31'd0, bus.rd_valid}, 32'd0);

      // Asynchronous reset mid-cycle with a live read output
      for (int i = 0; i < 6; i++) cyc(1, 16'hB000 + DW'(i), 0, 0);
      cyc(0, '0, 1, 0);
      check("pre_rst_state", {10'd0, bus.count, bus.rd_valid, bus.rd_data}, {10'd0, 5'd5, 1'b1, 16'hB000});
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      check("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
      check("rst_count", {27'd0, bus.count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc(0, '0, 1, 0);
      cyc(1, 16'h7777, 0, 0);
      cyc(0, '0, 1, 0);
      check("post_rst_rd", {15'd0, bus.rd_valid, bus.rd_data}, 32'h1_7777);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
